// File: rtl/core_ctrl_sequencer.sv
// Instruction sequencer for the 16-bit ALU datapath: fetch / decode / execute control FSM.
// Issues ALU opcode, source-select and write-enable strobes for one EXEC cycle per instruction.
module core_ctrl_sequencer #(
    parameter int unsigned PC_W = 8,
    parameter int unsigned NREG = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [15:0]     instr_data,
    input  logic            z,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      alu_op,
    output logic [3:0]      bus_sel,
    output logic            imm_sel,
    output logic [7:0]      imm,
    output logic            ac_we,
    output logic [NREG-1:0] reg_we,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StFinish
    } state_e;

    localparam logic [3:0] OpNop  = 4'd0;
    localparam logic [3:0] OpAdd  = 4'd1;
    localparam logic [3:0] OpSub  = 4'd2;
    localparam logic [3:0] OpMul  = 4'd3;
    localparam logic [3:0] OpDiv  = 4'd4;
    localparam logic [3:0] OpLdac = 4'd5;
    localparam logic [3:0] OpMod  = 4'd6;
    localparam logic [3:0] OpStac = 4'd7;
    localparam logic [3:0] OpJmp  = 4'd8;
    localparam logic [3:0] OpJmpz = 4'd9;
    localparam logic [3:0] OpLdi  = 4'd10;
    localparam logic [3:0] OpEnd  = 4'd15;

    localparam logic [2:0] AluAdd  = 3'd0;
    localparam logic [2:0] AluSub  = 3'd1;
    localparam logic [2:0] AluMul  = 3'd2;
    localparam logic [2:0] AluDiv  = 3'd3;
    localparam logic [2:0] AluPass = 3'd4;
    localparam logic [2:0] AluMod  = 3'd5;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;

    logic [3:0]      ir_op;
    logic [3:0]      ir_reg;
    logic [PC_W-1:0] ir_target;
    logic [PC_W-1:0] pc_inc;
    logic            in_exec;

    assign ir_op     = ir_q[15:12];
    assign ir_reg    = ir_q[11:8];
    assign ir_target = ir_q[PC_W-1:0];
    // Natural overflow gives the wrap from the last address back to 0.
    assign pc_inc    = pc_q + PC_W'(1);
    assign in_exec   = (state_q == StExec);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                // Synchronous ROM: data for the FETCH address is valid now.
                ir_d    = instr_data;
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch;
                case (ir_op)
                    OpEnd:   state_d = StFinish;
                    OpJmp:   pc_d    = ir_target;
                    OpJmpz:  pc_d    = z ? ir_target : pc_inc;
                    default: pc_d    = pc_inc;
                endcase
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath strobes exist only in EXEC; everything else sees zeros.
    always_comb begin
        alu_op  = AluAdd;
        bus_sel = 4'd0;
        imm_sel = 1'b0;
        ac_we   = 1'b0;
        reg_we  = '0;
        if (in_exec) begin
            case (ir_op)
                OpAdd, OpSub, OpMul, OpDiv, OpLdac, OpMod, OpLdi: begin
                    ac_we   = 1'b1;
                    bus_sel = ir_reg;
                end
                default: ;
            endcase
            case (ir_op)
                OpAdd:   alu_op = AluAdd;
                OpSub:   alu_op = AluSub;
                OpMul:   alu_op = AluMul;
                OpDiv:   alu_op = AluDiv;
                OpLdac:  alu_op = AluPass;
                OpMod:   alu_op = AluMod;
                OpLdi: begin
                    alu_op  = AluPass;
                    imm_sel = 1'b1;
                end
                default: alu_op = AluAdd;
            endcase
            if (ir_op == OpStac) begin
                // Register indices at or above NREG match no bit, so STAC degrades to NOP.
                for (int unsigned i = 0; i < NREG; i++) begin
                    reg_we[i] = (ir_reg == 4'(i));
                end
            end
        end
    end

    assign pc   = pc_q;
    assign imm  = ir_q[7:0];
    assign busy = (state_q != StIdle);
    assign done = (state_q == StFinish);

endmodule

// File: tb/tb_core_ctrl_sequencer.sv
// Directed bench for core_ctrl_sequencer with a synchronous instruction ROM model.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_core_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] instr_data = 16'h0000;
    logic        z = 1'b0;
    logic [7:0]  pc;
    logic [2:0]  alu_op;
    logic [3:0]  bus_sel;
    logic        imm_sel;
    logic [7:0]  imm;
    logic        ac_we;
    logic [7:0]  reg_we;
    logic        busy;
    logic        done;

    logic [15:0] mem [256];

    int total = 0;
    int bad   = 0;

    core_ctrl_sequencer #(
        .PC_W (8),
        .NREG (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .instr_data (instr_data),
        .z          (z),
        .pc         (pc),
        .alu_op     (alu_op),
        .bus_sel    (bus_sel),
        .imm_sel    (imm_sel),
        .imm        (imm),
        .ac_we      (ac_we),
        .reg_we     (reg_we),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) instr_data <= mem[pc];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulse start across one rising edge; returns in the first FETCH cycle.
    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_alu_op"}, alu_op, 0);
        check_val({tag, "_bus_sel"}, bus_sel, 0);
        check_val({tag, "_imm_sel"}, imm_sel, 0);
        check_val({tag, "_ac_we"}, ac_we, 0);
        check_val({tag, "_reg_we"}, reg_we, 0);
    endtask

    int exp_op [10] = '{1, 2, 3, 4, 5, 0, 0, 0, 0, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // Reset and idle.
        @(negedge clk);
        step();
        rst = 1'b0;
        check_val("rst_pc", pc, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_imm", imm, 0);
        check_quiet("rst");
        for (int c = 0; c < 10; c++) begin
            step();
            check_val("idle_pc", pc, 0);
            check_val("idle_busy", busy, 0);
            check_val("idle_done", done, 0);
            check_quiet("idle");
        end

        // Straight-line program: LDI 5; ADD r2; STAC r3; END.
        mem[0] = 16'hA005;
        mem[1] = 16'h1200;
        mem[2] = 16'h7300;
        mem[3] = 16'hF000;
        kick();
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) step();
            check_val("a_ac_we", ac_we, (c == 3 || c == 6));
            check_val("a_reg_we", reg_we, (c == 9) ? 8'h08 : 8'h00);
            check_val("a_imm_sel", imm_sel, (c == 3));
            check_val("a_done", done, (c == 13));
            check_val("a_busy", busy, (c <= 13));
            if (c == 3) begin
                check_val("a_ldi_op", alu_op, 4);
                check_val("a_ldi_imm", imm, 5);
                check_val("a_ldi_pc", pc, 0);
            end
            if (c == 6) begin
                check_val("a_add_op", alu_op, 0);
                check_val("a_add_sel", bus_sel, 2);
            end
            start = (c == 5);
        end
        start = 1'b0;

        // Op coverage: SUB, MUL, DIV, LDAC, MOD r1; opcodes 11-14; END.
        mem[0] = 16'h2100;
        mem[1] = 16'h3100;
        mem[2] = 16'h4100;
        mem[3] = 16'h5100;
        mem[4] = 16'h6100;
        mem[5] = 16'hB100;
        mem[6] = 16'hC100;
        mem[7] = 16'hD100;
        mem[8] = 16'hE100;
        mem[9] = 16'hF000;
        kick();
        for (int k = 0; k < 10; k++) begin
            step();
            step();
            check_val("b_pc", pc, k);
            check_val("b_alu_op", alu_op, exp_op[k]);
            check_val("b_bus_sel", bus_sel, (k < 5) ? 1 : 0);
            check_val("b_ac_we", ac_we, (k < 5));
            check_val("b_reg_we", reg_we, 0);
            step();
            if (k < 9) check_val("b_next_pc", pc, k + 1);
            else check_val("b_done", done, 1);
        end
        step();
        check_val("b_idle", busy, 0);

        // Wrap: JMP 0xFF, NOP at 0xFF, then END at 0.
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h80FF;
        kick();
        step();
        step();
        mem[0] = 16'hF000;
        step();
        check_val("w_pc_ff", pc, 8'hFF);
        step();
        step();
        check_quiet("w_nop");
        step();
        check_val("w_pc_wrap", pc, 0);
        step();
        step();
        step();
        check_val("w_done", done, 1);
        step();
        check_val("w_idle", busy, 0);

        // Branches, STAC r12, then reset in DECODE of an ADD.
        mem[0]    = 16'h7C00;
        mem[1]    = 16'h9020;
        mem[2]    = 16'h9020;
        mem[8'h20] = 16'h8007;
        mem[7]    = 16'h8000;
        kick();
        step();
        step();
        check_val("c_stac12_we", reg_we, 0);
        step();
        check_val("c_stac12_pc", pc, 1);
        step();
        step();
        z = 1'b0;
        step();
        check_val("c_jmpz_nt", pc, 2);
        step();
        step();
        z = 1'b1;
        step();
        z = 1'b0;
        check_val("c_jmpz_t", pc, 8'h20);
        step();
        step();
        step();
        check_val("c_jmp7", pc, 7);
        mem[0] = 16'h1200;
        step();
        step();
        step();
        check_val("c_jmp0", pc, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("r_ac_we", ac_we, 0);
        check_val("r_busy", busy, 0);
        check_val("r_pc", pc, 0);
        check_val("r_done", done, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            check_val("r_after_done", done, 0);
            check_val("r_after_ac_we", ac_we, 0);
            check_val("r_after_busy", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_ctrl_sequencer.md
# core_ctrl_sequencer

Instruction sequencer driving the core's 16-bit ALU datapath. Fetches 16-bit instruction words from the core's instruction memory, decodes them, and issues `alu_op`, source-select and write-enable strobes for one execute cycle per instruction. It is the control-side producer of the ALU opcode interface: add, sub, mul, div, pass and mod (ALU codes 0–5).

## Interface
Parameters:
- `PC_W`, 8: program counter width. The instruction memory depth is 2^PC_W.
- `NREG`, 8: number of general registers. Must be ≤ 16.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin program at pc 0; sampled only in IDLE.
- `instr_data`  in  16  instruction memory read data; valid the cycle after `pc` is presented (synchronous ROM).
- `z`  in  1  accumulator-zero flag (AC == 0) from the datapath.
- `pc`  out  PC_W  instruction memory address.
- `alu_op`  out  3  ALU operation code.
- `bus_sel`  out  4  source register index driven onto the ALU's in2 bus.
- `imm_sel`  out  1  selects the `imm` field instead of a register as the in2 source.
- `imm`  out  8  immediate, which is `ir[7:0]`.
- `ac_we`  out  1  accumulator load from `alu_out`.
- `reg_we`  out  NREG  one-hot register write enable; the write data is AC.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when END retires.

## Operation
- Instruction format: `ir[15:12]` opcode, `ir[11:8]` register r, `ir[7:0]` imm/target address.
- Opcodes:
  - 0 NOP.
  - 1 ADD r: `alu_op` = 0.
  - 2 SUB r: `alu_op` = 1.
  - 3 MUL r: `alu_op` = 2.
  - 4 DIV r: `alu_op` = 3, giving r / AC.
  - 5 LDAC r: `alu_op` = 4.
  - 6 MOD r: `alu_op` = 5, giving r % AC.
  - 7 STAC r: `reg_we[r]` = 1.
  - 8 JMP a.
  - 9 JMPZ a.
  - 10 LDI imm: `alu_op` = 4, `imm_sel` = 1.
  - 15 END.
  - 11–14 are treated as NOP.
- For opcodes 1–6 and 10: `ac_we` = 1 and `bus_sel` = r.
- For STAC with r ≥ NREG: no `reg_we` bit is set, and the instruction otherwise behaves as NOP.
- For JMP and JMPZ, the target is `ir[PC_W-1:0]`. Target bits above PC_W are ignored.
- FSM states: IDLE, FETCH, DECODE, EXEC, FINISH.
  - IDLE: when `start` = 1, set pc ← 0 and go to FETCH. Otherwise stay in IDLE.
  - FETCH: `pc` is presented to the memory. Go to DECODE.
  - DECODE: ir ← `instr_data`. Go to EXEC.
  - EXEC: the strobes are asserted for exactly this cycle.
    - END: go to FINISH; pc is not changed.
    - JMP: pc ← target.
    - JMPZ: if `z` = 1, pc ← target; otherwise pc ← pc+1.
    - All other opcodes: pc ← pc+1.
    - Every opcode except END then goes to FETCH.
  - FINISH: `done` = 1. Go to IDLE.
- pc increment wraps modulo 2^PC_W. Address 2^PC_W−1 is followed by address 0.
- Strobes are decoded from ir and gated by state == EXEC. Outside EXEC, `alu_op`, `bus_sel`, `imm_sel`, `ac_we` and `reg_we` are all 0.
- `start` is ignored while `busy` = 1.

## Timing
- Reset values: state IDLE, `pc` = 0, ir = 0, `alu_op` = 0, `bus_sel` = 0, `imm_sel` = 0, `imm` = 0, `ac_we` = 0, `reg_we` = 0, `busy` = 0, `done` = 0.
- `rst` asserted in any state returns the block to IDLE on the next edge. No strobe or `done` is issued in that cycle, and the current instruction is abandoned.
- Each instruction takes 3 cycles (FETCH, DECODE, EXEC).
- `start` high at edge t gives FETCH in cycle t+1 and the first EXEC in cycle t+3.
- `done` follows the END EXEC cycle by 1 cycle. `busy` falls in the cycle after `done`.
- `z` is sampled at the EXEC edge of JMPZ. Because the datapath updates AC at the same edge as a write, `z` reflects the AC written by any preceding instruction.
- `imm` is updated whenever ir is loaded. It is valid throughout EXEC.
- Write enables are single-cycle pulses. There are no back-to-back EXEC cycles.

## Test plan
- Reset/idle: hold `rst` for 2 cycles, then keep `start` = 0 for 10 cycles. Required: `pc` = 0, `busy` = 0, every strobe = 0, `done` never asserts.
- Straight-line program LDI 5; ADD r2; STAC r3; END, with the memory model returning words 0xA005, 0x1200, 0x7300, 0xF000:
  - EXEC strobes occur at cycles 3, 6, 9 after `start`.
  - LDI: `alu_op` = 4, `imm_sel` = 1, `imm` = 5.
  - ADD: `alu_op` = 0, `bus_sel` = 2, `ac_we` = 1.
  - STAC: `reg_we` = 0x08.
  - `done` pulses at cycle 13. `start` pulses during the run are ignored.
- Op coverage: for SUB, MUL, DIV, LDAC, MOD on r1, `alu_op` = 1, 2, 3, 4, 5 respectively with `bus_sel` = 1. Opcodes 11–14 produce no strobe and pc+1.
- Branches:
  - JMPZ 0x20 with `z` = 1 → next `pc` = 0x20.
  - JMPZ 0x20 with `z` = 0 → next `pc` = old+1.
  - JMP 0x00 from pc 0x07 → next `pc` = 0.
  - STAC r12 (with NREG = 8) → `reg_we` = 0.
- Wrap: NOP at pc 0xFF (PC_W = 8) → next FETCH `pc` = 0x00.
- Reset mid-operation: assert `rst` during DECODE of an ADD. Required: no `ac_we` pulse, state IDLE next cycle, `pc` = 0, and `done` stays 0.
